// File: rtl/calc_core.sv
// Accumulator calculator core: debounced power/send buttons, five-state control FSM, 16-bit ALU.
// Define CALC_MUL_EN to compile in the 8-cycle shift-add multiplier and its MUL state.
module calc_core #(
    parameter int DB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_power,
    input  logic        btn_send,
    input  logic [2:0]  op_selc,
    input  logic [7:0]  operand,
    output logic [15:0] result,
    output logic [3:0]  logger,
    output logic        power_on,
    output logic        result_valid
);
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_IDLE = 3'd1,
        S_EXEC = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [1:0]     btn_s, sync1_r, sync2_r, level_r, level_d_r, pulse_s;
    logic [DBW-1:0] db_cnt_r [2];
    logic           power_pulse_s, send_pulse_s;
    logic           load_s, exec_s, kill_s;
    logic [2:0]     op_r;
    logic [7:0]     operand_r;
    logic [15:0]    acc_r, ext_s, exec_acc_s;
    logic [16:0]    sum_s, dif_s;
    logic [3:0]     logger_r, exec_flags_s;
    logic           exec_ovf_s, exec_err_s;
    logic           power_on_r, result_valid_r;

    assign btn_s = {btn_send, btn_power};

    // Synchronize both buttons, then accept a new level only after DB_CYCLES agreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r   <= 2'b00;
            sync2_r   <= 2'b00;
            level_r   <= 2'b00;
            level_d_r <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt_r[i] <= {DBW{1'b0}};
        end else begin
            sync1_r   <= btn_s;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == level_r[i]) begin
                    db_cnt_r[i] <= {DBW{1'b0}};
                end else if (db_cnt_r[i] == DB_LAST) begin
                    level_r[i]  <= sync2_r[i];
                    db_cnt_r[i] <= {DBW{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + {{(DBW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign pulse_s       = level_r & ~level_d_r;
    assign power_pulse_s = pulse_s[0];
    assign send_pulse_s  = pulse_s[1];

`ifdef CALC_MUL_EN
    logic [23:0] mcand_r, prod_r, partial_s, prod_nxt_s;
    logic [7:0]  mplier_r;
    logic [2:0]  mul_cnt_r;
    logic        mul_step_s, mul_last_s, mul_ovf_s;
`endif

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_OFF;
        else     state_r <= state_nxt_s;
    end

    // Next-state logic; a power pulse always wins over send.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_OFF:  state_nxt_s = power_pulse_s ? S_IDLE : S_OFF;
            S_IDLE: begin
                if (power_pulse_s) begin
                    state_nxt_s = S_OFF;
                end else if (send_pulse_s) begin
`ifdef CALC_MUL_EN
                    state_nxt_s = (op_selc == 3'b110) ? S_MUL : S_EXEC;
`else
                    state_nxt_s = S_EXEC;
`endif
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_EXEC: state_nxt_s = power_pulse_s ? S_OFF : S_DONE;
`ifdef CALC_MUL_EN
            S_MUL: begin
                if (power_pulse_s)            state_nxt_s = S_OFF;
                else if (mul_cnt_r == 3'd7)   state_nxt_s = S_DONE;
                else                          state_nxt_s = S_MUL;
            end
`endif
            S_DONE: state_nxt_s = power_pulse_s ? S_OFF : S_IDLE;
            default: state_nxt_s = S_OFF;
        endcase
    end

    // Datapath strobes decoded from the current state.
    always_comb begin
        load_s = 1'b0;
        exec_s = 1'b0;
        kill_s = 1'b0;
`ifdef CALC_MUL_EN
        mul_step_s = 1'b0;
`endif
        if ((state_r != S_OFF) && power_pulse_s) begin
            kill_s = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: load_s = send_pulse_s;
                S_EXEC: exec_s = 1'b1;
`ifdef CALC_MUL_EN
                S_MUL:  mul_step_s = 1'b1;
`endif
                default: load_s = 1'b0;
            endcase
        end
    end

    // Single-cycle ALU operating on the latched op and sign-extended operand.
    always_comb begin
        ext_s      = {{8{operand_r[7]}}, operand_r};
        sum_s      = {acc_r[15], acc_r} + {ext_s[15], ext_s};
        dif_s      = {acc_r[15], acc_r} - {ext_s[15], ext_s};
        exec_acc_s = acc_r;
        exec_ovf_s = 1'b0;
        exec_err_s = 1'b0;
        case (op_r)
            3'b000: begin exec_acc_s = sum_s[15:0]; exec_ovf_s = sum_s[16] ^ sum_s[15]; end
            3'b001: begin exec_acc_s = dif_s[15:0]; exec_ovf_s = dif_s[16] ^ dif_s[15]; end
            3'b010: exec_acc_s = acc_r & ext_s;
            3'b011: exec_acc_s = acc_r | ext_s;
            3'b100: exec_acc_s = acc_r ^ ext_s;
            3'b101: begin exec_acc_s = 16'd0 - acc_r; exec_ovf_s = (acc_r == 16'h8000); end
            3'b111: exec_acc_s = 16'd0;
            default: exec_err_s = 1'b1;
        endcase
        exec_flags_s = {exec_ovf_s, (exec_acc_s == 16'd0), exec_acc_s[15], exec_err_s};
    end

`ifdef CALC_MUL_EN
    // Signed shift-add: bit 7 of the multiplier carries negative weight, so its step subtracts.
    always_comb begin
        partial_s  = mplier_r[0] ? mcand_r : 24'd0;
        prod_nxt_s = (mul_cnt_r == 3'd7) ? (prod_r - partial_s) : (prod_r + partial_s);
        mul_last_s = mul_step_s && (mul_cnt_r == 3'd7);
        mul_ovf_s  = (prod_nxt_s[23:15] != 9'h000) && (prod_nxt_s[23:15] != 9'h1FF);
    end

    // Multiplier working registers, loaded on send and stepped once per MUL cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r   <= 24'd0;
            mplier_r  <= 8'd0;
            prod_r    <= 24'd0;
            mul_cnt_r <= 3'd0;
        end else if (load_s) begin
            mcand_r   <= {{8{acc_r[15]}}, acc_r};
            mplier_r  <= operand;
            prod_r    <= 24'd0;
            mul_cnt_r <= 3'd0;
        end else if (mul_step_s) begin
            mcand_r   <= {mcand_r[22:0], 1'b0};
            mplier_r  <= {1'b0, mplier_r[7:1]};
            prod_r    <= prod_nxt_s;
            mul_cnt_r <= mul_cnt_r + 3'd1;
        end else begin
            mul_cnt_r <= mul_cnt_r;
        end
    end
`endif

    // Accumulator, flags, operand latch and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r          <= 16'd0;
            logger_r       <= 4'd0;
            op_r           <= 3'd0;
            operand_r      <= 8'd0;
            power_on_r     <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            if (kill_s) begin
                acc_r    <= 16'd0;
                logger_r <= 4'd0;
            end else if (exec_s) begin
                acc_r    <= exec_acc_s;
                logger_r <= exec_flags_s;
`ifdef CALC_MUL_EN
            end else if (mul_last_s) begin
                acc_r    <= prod_nxt_s[15:0];
                logger_r <= {mul_ovf_s, (prod_nxt_s[15:0] == 16'd0), prod_nxt_s[15], 1'b0};
`endif
            end else begin
                acc_r    <= acc_r;
            end
            if (load_s) begin
                op_r      <= op_selc;
                operand_r <= operand;
            end
            power_on_r     <= (state_nxt_s != S_OFF);
            result_valid_r <= (state_nxt_s == S_DONE);
        end
    end

    assign result       = acc_r;
    assign logger       = logger_r;
    assign power_on     = power_on_r;
    assign result_valid = result_valid_r;

endmodule

// File: doc/calc_core.md
CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 Parameter DB_CYCLES, default 500000, button debounce stability window in clk cycles (10 ms at 50 MHz); benches override it to 4.
REQ-002 clk  input  1  50 MHz system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 btn_power  input  1  raw power push-button, asynchronous to clk, active-high.
REQ-005 btn_send  input  1  raw send push-button, asynchronous to clk, active-high.
REQ-006 op_selc  input  3  operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NEG, 110 MUL, 111 CLR.
REQ-007 operand  input  8  signed two's-complement operand from switches.
REQ-008 result  output  16  signed accumulator value, registered; feeds the LCD display stage.
REQ-009 logger  output  4  status flags, registered: [3] overflow, [2] zero, [1] negative, [0] error.
REQ-010 power_on  output  1  high while calculator is on.
REQ-011 result_valid  output  1  one-cycle pulse when result/logger update.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after DB_CYCLES consecutive identical samples.
REQ-013 A debounced rising edge SHALL produce exactly one internal 1-cycle pulse; holding the button SHALL produce no further pulses.
REQ-014 FSM states: OFF, IDLE, EXEC, MUL, DONE.
REQ-015 OFF: power pulse -> IDLE with power_on=1; send pulses ignored.
REQ-016 IDLE: send pulse latches op_selc and operand; next state is MUL if the latched op is 110 (with MUL_EN), otherwise EXEC.
REQ-017 EXEC (1 cycle): accumulator = f(acc, sign-extended operand); flags updated; next state DONE.
REQ-018 DONE (1 cycle): result_valid=1; next state IDLE; operation latency from send pulse to result_valid is 2 cycles.
REQ-019 ADD/SUB SHALL wrap at 16 bits; overflow=1 when operand signs make the true sum/difference exceed -32768..32767.
REQ-020 AND/OR/XOR SHALL operate bitwise on the 16-bit sign-extended operand; overflow=0.
REQ-021 NEG: acc = -acc; overflow=1 only for acc=-32768, which remains -32768.
REQ-022 CLR: acc=0, all flags 0 except zero=1.
REQ-023 MUL: sequential signed shift-add, exactly 8 cycles in MUL, then DONE; result = low 16 bits of the product; overflow=1 if the product lies outside the 16-bit range.
REQ-024 zero = (new acc == 0); negative = new acc[15]; error=0 for every valid op.
REQ-025 Send pulses during EXEC, MUL or DONE SHALL be dropped, not queued.
REQ-026 Power pulse in IDLE/EXEC/MUL/DONE -> OFF on the next cycle: any MUL in progress is aborted, acc and logger cleared to 0, power_on=0, and no result_valid pulse.
REQ-027 Power and send pulses in the same cycle: power wins and send is dropped.
REQ-028 result and logger SHALL hold their values between updates.

Reset
REQ-029 rst=1 SHALL asynchronously force state OFF, result=0, logger=0, power_on=0, result_valid=0, and clear the synchronizer, debouncer and edge-detector registers to 0.
REQ-030 Reset mid-MUL SHALL abort the operation with no result_valid pulse after release.

Configuration
REQ-031 Macro CALC_MUL_EN defined: the multiplier and the MUL state are compiled in; op 110 behaves per REQ-023.
REQ-032 CALC_MUL_EN undefined: there is no multiplier logic; op 110 goes through EXEC with acc unchanged, error=1, overflow=0, zero/negative recomputed, and result_valid still pulses.

Verification
REQ-033 Reset, power pulse, op ADD, operand 8'sd100, send -> result=100, logger=0000, result_valid 2 cycles after send pulse.
REQ-034 acc=32767, ADD operand 1 -> result=-32768, logger=1010.
REQ-035 acc=-300, MUL operand -5 (CALC_MUL_EN) -> result=1500 after 8 MUL cycles, logger=0000; the same case without the macro -> result=-300, logger=0011.
REQ-036 Send held high for 50 cycles with DB_CYCLES=4 -> exactly one operation; a 2-cycle glitch -> no operation.
REQ-037 Power pulse in cycle 3 of MUL -> next cycle OFF, result=0, logger=0, no result_valid; a subsequent send is ignored.
REQ-038 Power and send edges in the same cycle while in IDLE -> OFF, with acc unchanged by the send.
